// File: rtl/pattern_frame_tx.sv
// Serial frame transmitter: prefixes each frame with the 11010 marker and bit-stuffs the payload
// so a downstream 11010 detector fires only on the marker.
module pattern_frame_tx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] In_Data,
  input  logic                  In_Last,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  output logic                  Bit_Out,
  output logic                  Bit_Valid,
  output logic                  Stuff_Flag,
  output logic                  Frame_Busy,
  output logic                  Underrun
);

  localparam int unsigned     IdxW    = $clog2(DATA_WIDTH);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);
  localparam logic [4:0]      Marker  = 5'b11010;

  typedef enum logic [2:0] {StIdle, StMarker, StPayload, StStuff, StFill} state_e;
  typedef enum logic [2:0] {TrS0, TrS1, TrS11, TrS110, TrS1101} track_e;

  state_e                state_q, state_d;
  track_e                track_q, track_d;
  logic [2:0]            mcnt_q, mcnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] buf_q;
  logic                  buf_last_q;
  logic                  buf_full_q, buf_full_d;
  logic                  bit_q, bit_d;
  logic                  valid_q, valid_d;
  logic                  stuff_q, stuff_d;
  logic                  busy_q, busy_d;
  logic                  underrun_q, underrun_d;
  logic                  accept;
  logic                  load;
  logic                  step;

  assign In_Ready   = ~buf_full_q;
  assign accept     = In_Valid & ~buf_full_q;
  assign Bit_Out    = bit_q;
  assign Bit_Valid  = valid_q;
  assign Stuff_Flag = stuff_q;
  assign Frame_Busy = busy_q;
  assign Underrun   = underrun_q;

  // Shadow of the line detector, fed with the bit currently on the line.
  always_comb begin
    track_d = TrS0;
    case (track_q)
      TrS0:    track_d = bit_q ? TrS1    : TrS0;
      TrS1:    track_d = bit_q ? TrS11   : TrS0;
      TrS11:   track_d = bit_q ? TrS11   : TrS110;
      TrS110:  track_d = bit_q ? TrS1101 : TrS0;
      TrS1101: track_d = bit_q ? TrS11   : TrS0;
      default: track_d = TrS0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mcnt_d     = mcnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    last_d     = last_q;
    load       = 1'b0;
    step       = 1'b0;
    bit_d      = 1'b0;
    valid_d    = 1'b0;
    stuff_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (buf_full_q) begin
          state_d = StMarker;
          mcnt_d  = 3'd0;
        end
      end
      StMarker: begin
        if (mcnt_q == 3'd4) begin
          state_d = StPayload;
          load    = 1'b1;
        end else begin
          mcnt_d = mcnt_q + 3'd1;
        end
      end
      // A stuff cycle defers the shift/word-end step so counters hold across it.
      StPayload: begin
        if (track_d == TrS1101) begin
          state_d = StStuff;
        end else begin
          step = 1'b1;
        end
      end
      StStuff: step = 1'b1;
      StFill: begin
        if (buf_full_q) begin
          state_d = StPayload;
          load    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (step) begin
      if (idx_q != IdxLast) begin
        state_d = StPayload;
        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
        idx_d   = idx_q + IdxW'(1);
      end else if (!last_q) begin
        if (buf_full_q) begin
          state_d = StPayload;
          load    = 1'b1;
        end else begin
          state_d = StFill;
        end
      end else if (buf_full_q) begin
        state_d = StMarker;
        mcnt_d  = 3'd0;
      end else begin
        state_d = StIdle;
      end
    end

    if (load) begin
      shift_d = buf_q;
      last_d  = buf_last_q;
      idx_d   = '0;
    end

    buf_full_d = accept ? 1'b1 : (load ? 1'b0 : buf_full_q);

    case (state_d)
      StMarker: begin
        bit_d   = Marker[3'd4 - mcnt_d];
        valid_d = 1'b1;
      end
      StPayload: begin
        bit_d   = shift_d[DATA_WIDTH-1];
        valid_d = 1'b1;
      end
      StStuff: begin
        bit_d   = 1'b1;
        valid_d = 1'b1;
        stuff_d = 1'b1;
      end
      default: ;
    endcase

    busy_d     = (state_d != StIdle);
    underrun_d = (state_d == StFill) && (state_q != StFill);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      track_q    <= TrS0;
      mcnt_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      buf_q      <= '0;
      buf_last_q <= 1'b0;
      buf_full_q <= 1'b0;
      bit_q      <= 1'b0;
      valid_q    <= 1'b0;
      stuff_q    <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      track_q    <= track_d;
      mcnt_q     <= mcnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      buf_full_q <= buf_full_d;
      bit_q      <= bit_d;
      valid_q    <= valid_d;
      stuff_q    <= stuff_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      if (accept) begin
        buf_q      <= In_Data;
        buf_last_q <= In_Last;
      end
    end
  end

endmodule

// File: tb/tb_pattern_frame_tx.sv
// Bench for pattern_frame_tx: directed frames plus random traffic against a line-level model
// built from queued marker/payload bits and the recent line history.
module tb_pattern_frame_tx;

  typedef struct packed {
    logic b;
    logic pay;
    logic mk_end;
    logic eof;
  } ebit_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] In_Data = '0;
  logic       In_Last = 1'b0;
  logic       In_Valid = 1'b0;
  logic       In_Ready, Bit_Out, Bit_Valid, Stuff_Flag, Frame_Busy, Underrun;

  int checks = 0;
  int errors = 0;

  // Line model state
  ebit_t       q[$];
  logic [3:0]  h = '0;
  logic [4:0]  hobs = '0;
  logic        stf_pend = 0, eof_pend = 0, in_frame = 0, gap_prev = 0, start_next = 1;
  logic        inc_v = 0, inc_l = 0;
  logic [7:0]  inc_d = '0;

  // Per-test recording
  int          obs_n = 0, det_cnt = 0, und_cnt = 0;
  logic [63:0] obs_bits = '0, obs_stf = '0;

  pattern_frame_tx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .In_Data    (In_Data),
    .In_Last    (In_Last),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Bit_Out    (Bit_Out),
    .Bit_Valid  (Bit_Valid),
    .Stuff_Flag (Stuff_Flag),
    .Frame_Busy (Frame_Busy),
    .Underrun   (Underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d, input logic l);
    ebit_t      x;
    logic [4:0] mk;
    mk = 5'b11010;
    if (start_next) begin
      for (int i = 0; i < 5; i++) begin
        x.b = mk[4-i]; x.pay = 1'b0; x.mk_end = (i == 4); x.eof = 1'b0;
        q.push_back(x);
      end
    end
    for (int i = 7; i >= 0; i--) begin
      x.b = d[i]; x.pay = 1'b1; x.mk_end = 1'b0; x.eof = l && (i == 0);
      q.push_back(x);
    end
    start_next = l;
  endtask

  // Each sample shows the bit chosen at the preceding edge; a word accepted at edge K may
  // appear on the line from edge K+1, never later if the line would otherwise idle.
  always @(negedge clk) begin : mon
    logic [4:0] e;
    logic       ed, dobs;
    ebit_t      eb;
    if (!reset) begin
      q.delete();
      h = '0; hobs = '0; stf_pend = 0; eof_pend = 0; in_frame = 0; gap_prev = 0;
      start_next = 1; inc_v = 0;
    end else begin
      hobs = {hobs[3:0], Bit_Out};
      dobs = (hobs == 5'b11010);
      ed   = 1'b0;
      if (stf_pend) begin
        e = 5'b11110;
        h = {h[2:0], 1'b1};
        stf_pend = 0;
        if (eof_pend) in_frame = 0;
        eof_pend = 0;
        gap_prev = 0;
      end else if (q.size() > 0) begin
        eb = q.pop_front();
        e  = {eb.b, 4'b1010};
        ed = eb.mk_end;
        h  = {h[2:0], eb.b};
        in_frame = 1;
        gap_prev = 0;
        if (eb.pay && h == 4'b1101) begin
          stf_pend = 1;
          eof_pend = eb.eof;
        end else if (eb.eof) begin
          in_frame = 0;
        end
      end else begin
        e = {3'b000, in_frame, in_frame & ~gap_prev};
        h = {h[2:0], 1'b0};
        gap_prev = in_frame;
      end
      check("line", 64'({Bit_Out, Bit_Valid, Stuff_Flag, Frame_Busy, Underrun}), 64'(e));
      check("detect", 64'(dobs), 64'(ed));
      if (Bit_Valid) begin
        obs_bits = {obs_bits[62:0], Bit_Out};
        obs_stf  = {obs_stf[62:0], Stuff_Flag};
        obs_n++;
      end
      if (dobs) det_cnt++;
      if (Underrun) und_cnt++;
      if (inc_v) push_word(inc_d, inc_l);
      inc_v = In_Valid & In_Ready;
      inc_d = In_Data;
      inc_l = In_Last;
    end
  end

  task automatic clear_rec();
    obs_n = 0; det_cnt = 0; und_cnt = 0; obs_bits = '0; obs_stf = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    logic acc;
    int   n;
    acc = 0; n = 0;
    In_Data = d; In_Last = l; In_Valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = In_Ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        check("handshake", 64'(acc), 64'(1));
        break;
      end
    end
    In_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || stf_pend || in_frame || inc_v) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(n < 1000), 64'(1));
    cycles(2);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_bit"}, 64'(Bit_Out), 64'(0));
    check({tag, "_valid"}, 64'(Bit_Valid), 64'(0));
    check({tag, "_stuff"}, 64'(Stuff_Flag), 64'(0));
    check({tag, "_busy"}, 64'(Frame_Busy), 64'(0));
    check({tag, "_under"}, 64'(Underrun), 64'(0));
    check({tag, "_ready"}, 64'(In_Ready), 64'(1));
  endtask

  task automatic single(input string tag, input logic [7:0] d, input int n,
                        input logic [63:0] bits, input logic [63:0] stf);
    clear_rec();
    send_word(d, 1'b1);
    wait_idle();
    check({tag, "_nbits"}, 64'(obs_n), 64'(n));
    check({tag, "_bits"}, obs_bits, bits);
    check({tag, "_stuff"}, obs_stf, stf);
    check({tag, "_det"}, 64'(det_cnt), 64'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int nframes;
    cycles(3);
    check_reset_outs("rst");
    reset = 1'b1;
    cycles(2);

    single("a5", 8'hA5, 13, 64'({5'b11010, 8'hA5}), 64'(0));
    single("d0", 8'hD0, 14, 64'(14'b11010_1101_1_0000), 64'(14'b00000000010000));
    single("6b", 8'h6B, 15, 64'(15'b11010_01101_1_01_1_1), 64'(15'b000000000010010));

    // Second word arrives 12 cycles after the first has drained (13 line cycles).
    clear_rec();
    send_word(8'h3C, 1'b0);
    cycles(13 + 12);
    send_word(8'hA5, 1'b1);
    wait_idle();
    check("late_under", 64'(und_cnt), 64'(1));
    check("late_det", 64'(det_cnt), 64'(1));
    check("late_nbits", 64'(obs_n), 64'(21));
    check("late_bits", obs_bits, 64'({5'b11010, 8'h3C, 8'hA5}));

    clear_rec();
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b1);
    wait_idle();
    check("b2b_nbits", 64'(obs_n), 64'(26));
    check("b2b_bits", obs_bits, 64'({5'b11010, 8'hFF, 5'b11010, 8'h00}));
    check("b2b_det", 64'(det_cnt), 64'(2));
    check("b2b_under", 64'(und_cnt), 64'(0));

    // Reset while payload bit 3 is on the line.
    clear_rec();
    send_word(8'hA5, 1'b1);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outs("midrst");
    check("midrst_pos", 64'(obs_n), 64'(8));
    cycles(3);
    reset = 1'b1;
    cycles(2);
    single("post", 8'hA5, 13, 64'({5'b11010, 8'hA5}), 64'(0));

    clear_rec();
    nframes = 30;
    for (int f = 0; f < nframes; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        send_word(8'($urandom), (w == nw - 1));
        if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 15));
      end
      cycles($urandom_range(0, 4));
    end
    wait_idle();
    check("rand_det", 64'(det_cnt), 64'(nframes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
